i2s_receiver: RTL and testbench
===============================

# i2s_receiver

Serial-to-parallel I2S receiver, the receive-side counterpart of the team's I2S transmitter. Accepts an external I2S stream (BCLK, WCLK, DATA) asynchronous to the system clock, oversamples it in the `clk_in` domain and recovers left/right words of `BITS` bits from 32-bit slots. Presents each stereo pair with a single-cycle `sample_pulse`. Used for audio loopback verification of the PSG/I2S path and for external codec ADC input.

## Interface
Parameters:
- `BITS`, 16: word width recovered per channel; legal range 8..24; the MSB-first top `BITS` bits of each 32-bit slot are kept.
- `INV_BCLK`, 0: 0 = sample DATA/WCLK on BCLK rising edge; 1 = on falling edge.

Ports:
- `clk_in`  in  1  system clock; all logic is in this domain.
- `rst`  in  1  reset, synchronous, active-high.
- `I2S_BCLK`  in  1  serial bit clock (async); 64 BCLK per stereo frame.
- `I2S_WCLK`  in  1  word clock (async); 0 = left slot, 1 = right slot.
- `I2S_DATA`  in  1  serial data (async), MSB first, one BCLK after each WCLK transition.
- `DAC_Left`  out  BITS  last complete left word (two's complement, passed through unaltered).
- `DAC_Right`  out  BITS  last complete right word.
- `sample_pulse`  out  1  one-`clk_in` strobe when `DAC_Left`/`DAC_Right` update.
- `locked`  out  1  high while slot framing is valid.
- `frame_err`  out  1  one-`clk_in` strobe on a bad slot length while locked.

## Operation
- Input conditioning:
  - `I2S_BCLK`, `I2S_WCLK` and `I2S_DATA` each pass through a 2-flop synchronizer.
  - BCLK has an extra history flop.
  - Active edge = `s2 & ~s3` (rising), or `~s2 & s3` when `INV_BCLK=1`.
- Per active edge, sample the synchronized WCLK (`w`) and DATA (`d`). `w_prev` holds the previous edge's `w`.
- Non-change edge (`w == w_prev`):
  - If `cnt < BITS`, shift `d` into `shreg` LSB.
  - `cnt <= cnt+1`, saturating at 63.
- Change edge (`w != w_prev`):
  - The sampled `d` is the LSB of the finished slot and is discarded.
  - The slot is valid iff `cnt == 31`, i.e. exactly 32 bits.
  - `cnt <= 0`; `shreg` is cleared.
- Finished slot with `w_prev == 0` (left): copy `shreg` into the internal `left_hold` register and record `left_ok = valid`.
- Finished slot with `w_prev == 1` (right): if `valid & left_ok & locked`, load `DAC_Left <= left_hold`, `DAC_Right <= shreg`, and pulse `sample_pulse`.
- Lock FSM, states `SEARCH`, `ALIGN`, `LOCKED`:
  - `SEARCH` → `ALIGN` on any change edge. This discards the partial slot seen after reset.
  - `ALIGN` → `LOCKED` after one valid slot ends. `ALIGN` → `SEARCH` on an invalid slot.
  - `LOCKED` → `SEARCH` on an invalid slot, with a `frame_err` pulse.
  - `locked = (state == LOCKED)`.
  - The first `sample_pulse` needs a valid left slot then a valid right slot, both ending while locked.
- Reset, effective on the next `clk_in` edge with `rst` high:
  - State `SEARCH`; `cnt = 63`.
  - `shreg`, `left_hold`, `DAC_Left`, `DAC_Right` = 0.
  - `sample_pulse`, `frame_err`, `locked` = 0; `left_ok = 0`; `w_prev = 0`.
  - Synchronizer flops = 0.
  - Reset mid-frame discards all partial data and restarts the lock sequence.
- Outputs hold their value between pulses. Loss of BCLK freezes all state; no timeout.

## Timing
- BCLK must satisfy f_BCLK ≤ f_clk_in/4, with each phase ≥ 2 `clk_in` cycles. Example: 3.072 MHz BCLK with a 100 MHz `clk_in`.
- Latency: define edge N as the `clk_in` edge at which the first synchronizer stage captures the BCLK transition. The shift, counter, FSM, `DAC_*`, `sample_pulse` and `frame_err` registers all update at edge N+2. The strobes are high for the cycle after edge N+2.
- WCLK and DATA use the same synchronizer depth, so they are sampled coherently with BCLK. The transmitter changes them on the opposite BCLK edge.
- `sample_pulse` period = 64 BCLK periods in steady state, ±1 `clk_in` of jitter.
- `sample_pulse` and `frame_err` are never high in the same cycle. An invalid right slot causes `frame_err` and no `sample_pulse`.

## Test plan
- Bench setup for all tests: `BITS=12`, `INV_BCLK=0`, 100 MHz `clk_in`, behavioural I2S source with BCLK = `clk_in`/32.
- Steady stream: Left=12'hA5C and Right=12'h3F1 every frame.
  - `locked` rises after the first valid slot.
  - The first `sample_pulse` arrives at the end of the first full left+right frame after lock, with `DAC_Left`=12'hA5C and `DAC_Right`=12'h3F1.
  - Pulse spacing is 2048±1 `clk_in` cycles.
- Sign and extremes: Left=12'h800, Right=12'h7FF, then 12'hFFF/12'h001 → outputs match exactly, with no sign manipulation.
- Short slot: one left slot of 31 bits while locked.
  - One `frame_err` pulse; `locked` = 0; no `sample_pulse` that frame; `DAC_*` unchanged.
  - Relock; `sample_pulse` resumes after one further valid left+right frame.
- Reset mid-frame: assert `rst` for 1 cycle at bit 10 of a right slot.
  - All outputs go to 0 on the next edge.
  - The partial slot is ignored, then normal lock and data resume.
- Loopback: connect the team's I2S transmitter (`BITS=12`, 3.072 MHz BCLK from fp_div) driven with a counting pattern.
  - Received `DAC_Left` equals the transmitted value with a fixed frame delay, for 1000 consecutive samples.
- `INV_BCLK=1` with a source shifting on BCLK rising → same values as the steady-stream test.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples an asynchronous BCLK/WCLK/DATA stream in the
// clk_in domain and recovers left/right words with slot-length framing checks.
module i2s_receiver #(
    parameter int BITS     = 16,
    parameter bit INV_BCLK = 1'b0
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            I2S_BCLK,
    input  logic            I2S_WCLK,
    input  logic            I2S_DATA,
    output logic [BITS-1:0] DAC_Left,
    output logic [BITS-1:0] DAC_Right,
    output logic            sample_pulse,
    output logic            locked,
    output logic            frame_err
);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } state_t;

    localparam logic [5:0] BITS_C = 6'(BITS);

    state_t          state;
    logic [2:0]      bclk_sync;
    logic [1:0]      wclk_sync;
    logic [1:0]      data_sync;
    logic [5:0]      cnt;
    logic [BITS-1:0] shreg;
    logic [BITS-1:0] left_hold;
    logic            left_ok;
    logic            w_prev;
    logic            w;
    logic            d;
    logic            edge_hit;
    logic            change;
    logic            valid;

    // Index 1 is the second synchronizer stage, index 2 the BCLK history flop.
    assign w        = wclk_sync[1];
    assign d        = data_sync[1];
    assign edge_hit = INV_BCLK ? (~bclk_sync[1] & bclk_sync[2])
                               : (bclk_sync[1] & ~bclk_sync[2]);
    assign change   = (w != w_prev);
    assign valid    = (cnt == 6'd31);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            bclk_sync    <= '0;
            wclk_sync    <= '0;
            data_sync    <= '0;
            state        <= SEARCH;
            locked       <= 1'b0;
            cnt          <= 6'd63;
            shreg        <= '0;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            w_prev       <= 1'b0;
            DAC_Left     <= '0;
            DAC_Right    <= '0;
            sample_pulse <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            bclk_sync    <= {bclk_sync[1:0], I2S_BCLK};
            wclk_sync    <= {wclk_sync[0], I2S_WCLK};
            data_sync    <= {data_sync[0], I2S_DATA};
            sample_pulse <= 1'b0;
            frame_err    <= 1'b0;
            if (edge_hit) begin
                w_prev <= w;
                if (!change) begin
                    if (cnt < BITS_C) begin
                        shreg <= {shreg[BITS-2:0], d};
                    end
                    if (cnt != 6'd63) begin
                        cnt <= cnt + 6'd1;
                    end
                end else begin
                    // d here is the old slot's LSB and is dropped
                    cnt   <= '0;
                    shreg <= '0;
                    if (!w_prev) begin
                        left_hold <= shreg;
                        left_ok   <= valid;
                    end else if (valid && left_ok && locked) begin
                        DAC_Left     <= left_hold;
                        DAC_Right    <= shreg;
                        sample_pulse <= 1'b1;
                    end
                    unique case (state)
                        SEARCH: begin
                            state  <= ALIGN;
                            locked <= 1'b0;
                        end
                        ALIGN: begin
                            state  <= valid ? LOCKED : SEARCH;
                            locked <= valid;
                        end
                        LOCKED: begin
                            if (!valid) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                frame_err <= 1'b1;
                            end
                        end
                        default: begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomized bench: slot-level I2S source and lock/word model driving
// two receivers (rising-edge and inverted-BCLK variants).
module tb_i2s_receiver;

    typedef struct packed {
        logic        w;
        logic        d;
        logic [11:0] word;
        logic        rst_here;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bclk = 1'b0;
    logic        bclk_n;
    logic        wclk = 1'b0;
    logic        data = 1'b0;
    logic [11:0] dl0, dr0, dl1, dr1;
    logic        sp0, lk0, fe0, sp1, lk1, fe1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ent_t        bq[$];
    logic [23:0] exp0[$];
    logic [23:0] exp1[$];

    int          m_stage = 0;
    bit          m_left_ok = 1'b0;
    logic [11:0] m_left = '0;
    int          m_ferr = 0;
    logic        m_last_w = 1'b0;
    int          m_run = 64;
    logic [11:0] m_val = '0;

    int          ferr0 = 0;
    int          ferr1 = 0;
    int          ov = 0;
    int          last0 = -1;
    int          last1 = -1;
    logic [11:0] hl0 = '0, hr0 = '0, hl1 = '0, hr1 = '0;

    assign bclk_n = ~bclk;

    always #5 clk = ~clk;

    i2s_receiver #(.BITS(12), .INV_BCLK(1'b0)) dut0 (
        .clk_in(clk), .rst(rst),
        .I2S_BCLK(bclk), .I2S_WCLK(wclk), .I2S_DATA(data),
        .DAC_Left(dl0), .DAC_Right(dr0),
        .sample_pulse(sp0), .locked(lk0), .frame_err(fe0)
    );

    i2s_receiver #(.BITS(12), .INV_BCLK(1'b1)) dut1 (
        .clk_in(clk), .rst(rst),
        .I2S_BCLK(bclk_n), .I2S_WCLK(wclk), .I2S_DATA(data),
        .DAC_Left(dl1), .DAC_Right(dr1),
        .sample_pulse(sp1), .locked(lk1), .frame_err(fe1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Slot-level view: a slot is a run of equal sampled WCLK values,
    // valid only when it spans exactly 32 BCLKs.
    task automatic model_slot(input bit was_left, input int len,
                              input logic [11:0] val);
        bit ok;
        ok = (len == 32);
        if (was_left) begin
            m_left    = val;
            m_left_ok = ok;
        end else if (ok && m_left_ok && m_stage == 2) begin
            exp0.push_back({m_left, val});
            exp1.push_back({m_left, val});
        end
        if (m_stage == 0) begin
            m_stage = 1;
        end else if (!ok) begin
            if (m_stage == 2) m_ferr++;
            m_stage = 0;
        end else begin
            m_stage = 2;
        end
    endtask

    task automatic model_reset();
        m_stage   = 0;
        m_left_ok = 1'b0;
        m_last_w  = 1'b0;
        m_run     = 64;
        last0     = -1;
        last1     = -1;
        hl0 = '0; hr0 = '0; hl1 = '0; hr1 = '0;
    endtask

    task automatic push_slot(input logic w, input logic [11:0] v,
                             input int n, input int rst_at);
        logic [31:0] word32;
        ent_t e;
        word32 = {v, 20'($urandom)};
        for (int b = 0; b < n; b++) begin
            e.w        = w;
            e.d        = word32[31-b];
            e.word     = v;
            e.rst_here = (b == rst_at);
            bq.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [11:0] l, input logic [11:0] r);
        push_slot(1'b0, l, 32, -1);
        push_slot(1'b1, r, 32, -1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_left0", dl0, 12'h000);
        check("rst_right0", dr0, 12'h000);
        check("rst_locked0", lk0, 1'b0);
        check("rst_pulse0", sp0, 1'b0);
        check("rst_left1", dl1, 12'h000);
        check("rst_right1", dr1, 12'h000);
        check("rst_locked1", lk1, 1'b0);
        model_reset();
    endtask

    // WCLK for each bit is the slot level of the following bit, so WCLK
    // changes together with the previous slot's LSB.
    task automatic run_stream();
        ent_t        e;
        logic        nw;
        logic [11:0] nv;
        while (bq.size() > 0) begin
            e = bq.pop_front();
            if (e.rst_here) do_reset();
            nw = e.w;
            nv = e.word;
            if (bq.size() > 0) begin
                nw = bq[0].w;
                nv = bq[0].word;
            end
            if (nw != m_last_w) begin
                model_slot(!m_last_w, m_run, m_val);
                m_run = 1;
                m_val = nv;
            end else if (m_run < 64) begin
                m_run++;
            end
            m_last_w = nw;
            wclk = nw;
            data = e.d;
            #160 bclk = 1'b1;
            #150;
            check("locked0", lk0, m_stage == 2);
            check("locked1", lk1, m_stage == 2);
            #10 bclk = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        logic [23:0] pr;
        cyc++;
        #1;
        if (sp0 && fe0) ov++;
        if (sp1 && fe1) ov++;
        if (sp0) begin
            if (exp0.size() == 0) begin
                check("pulse0_extra", 1, 0);
            end else begin
                pr = exp0.pop_front();
                check("left0", dl0, pr[23:12]);
                check("right0", dr0, pr[11:0]);
                hl0 = pr[23:12];
                hr0 = pr[11:0];
            end
            if (last0 >= 0)
                check("spacing0", (cyc - last0 >= 2047) && (cyc - last0 <= 2049), 1);
            last0 = cyc;
        end
        if (sp1) begin
            if (exp1.size() == 0) begin
                check("pulse1_extra", 1, 0);
            end else begin
                pr = exp1.pop_front();
                check("left1", dl1, pr[23:12]);
                check("right1", dr1, pr[11:0]);
                hl1 = pr[23:12];
                hr1 = pr[11:0];
            end
            if (last1 >= 0)
                check("spacing1", (cyc - last1 >= 2047) && (cyc - last1 <= 2049), 1);
            last1 = cyc;
        end
        if (fe0) begin
            ferr0++;
            last0 = -1;
            check("hold_left0", dl0, hl0);
            check("hold_right0", dr0, hr0);
        end
        if (fe1) begin
            ferr1++;
            last1 = -1;
            check("hold_left1", dl1, hl1);
            check("hold_right1", dr1, hr1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrand;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        check("init_left0", dl0, 12'h000);
        check("init_right0", dr0, 12'h000);
        check("init_locked0", lk0, 1'b0);
        check("init_ferr0", fe0, 1'b0);
        check("init_locked1", lk1, 1'b0);
        model_reset();

        for (int i = 0; i < 6; i++) push_frame(12'hA5C, 12'h3F1);
        push_frame(12'h800, 12'h7FF);
        push_frame(12'hFFF, 12'h001);
        push_slot(1'b0, 12'hA5C, 31, -1);
        push_slot(1'b1, 12'h3F1, 32, -1);
        for (int i = 0; i < 3; i++)
            push_frame(12'($urandom), 12'($urandom));
        push_slot(1'b0, 12'h123, 32, -1);
        push_slot(1'b1, 12'h456, 32, 10);
        for (int i = 0; i < 4; i++)
            push_frame(12'($urandom), 12'($urandom));
        nrand = int'($urandom_range(5, 8));
        for (int i = 0; i < nrand; i++)
            push_frame(12'($urandom), 12'($urandom));
        push_slot(1'b0, 12'h000, 32, -1);

        run_stream();
        repeat (300) @(posedge clk);
        #2;
        check("pending0", exp0.size(), 0);
        check("pending1", exp1.size(), 0);
        check("ferr_count0", ferr0, m_ferr);
        check("ferr_count1", ferr1, m_ferr);
        check("pulse_err_overlap", ov, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
